pwm_duty_sequencer: RTL
=======================

Name: pwm_duty_sequencer

Overview:
Controller that sits in front of the PWM datapath and owns its duty-cycle register. It takes a target duty from a valid/ready load port or from single-cycle inc/dec pulses. It ramps the applied duty toward the target one step per STEP_DIV PWM periods, and changes duty only at a period boundary so the PWM output never glitches. A kill input forces duty to zero immediately.

Parameters:
DUTY_W, 4, width of duty/target values
DUTY_MAX, 10, maximum duty code (100% at a 10-count PWM period)
DUTY_INIT, 5, duty/target value after reset
STEP_DIV, 4, PWM periods between ramp steps (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
period_end  in  1  one-cycle pulse from the PWM counter on its wrap cycle
inc_pulse  in  1  one-cycle request: target +1
dec_pulse  in  1  one-cycle request: target -1
load_valid  in  1  load request valid
load_duty  in  DUTY_W  requested target for load
load_ready  out  1  load accepted when load_valid && load_ready
kill  in  1  level: force duty 0, target 0
duty  out  DUTY_W  applied duty to the PWM comparator
target  out  DUTY_W  current target
busy  out  1  high while duty != target
at_target  out  1  registered one-cycle pulse on the cycle after duty first equals target

Behaviour:
- Reset (async, rst=1): duty=DUTY_INIT, target=DUTY_INIT, step counter=0, state IDLE, busy=0, at_target=0, load_ready=0. Outputs stay at these values while rst is high.
- FSM states:
  - IDLE: duty==target. Go to RAMP when target != duty.
  - RAMP: on each period_end, step_cnt increments. When step_cnt==STEP_DIV-1 on a period_end, step_cnt returns to 0 and duty moves 1 toward target. Return to IDLE the cycle after duty==target; at_target pulses on that transition.
  - KILLED: entered whenever kill=1, from any state.
- Target update priority, evaluated each cycle when kill=0:
  1. A load handshake sets target=min(load_duty, DUTY_MAX).
  2. Otherwise, inc_pulse && !dec_pulse sets target=target+1, saturating at DUTY_MAX.
  3. Otherwise, dec_pulse && !inc_pulse sets target=target-1, saturating at 0.
  4. inc && dec together: no change.
  5. If a load handshake and a pulse occur in the same cycle, the pulse is dropped.
- load_ready=1 in IDLE and RAMP, 0 in KILLED and reset. A retarget during RAMP takes effect immediately; the ramp direction follows the new target, and step_cnt is not cleared.
- The target register updates one cycle after the request. duty never changes except on a period_end cycle or on kill.
- No overshoot: when target is crossed by a retarget, duty still moves exactly one step per step event.
- KILLED:
  - On kill=1, duty=0 and target=0 on the next clk edge, independent of period_end; step_cnt=0.
  - kill has priority over load, inc and dec; all three are ignored while kill=1.
  - Leave to IDLE the first cycle kill=0, with duty=target=0.
- busy = (duty != target) registered alongside duty/target, so it has zero extra latency relative to them.
- Arithmetic: saturating, never wraps; values above DUTY_MAX are unreachable.

Optional Feature:
SOFT_START_EN:
- Defined: reset leaves duty=0 and target=DUTY_INIT, state RAMP, busy=1. The block ramps up after reset, and at_target pulses when duty reaches DUTY_INIT.
- Undefined: reset values are as stated in Behaviour, with no ramp after reset.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum typedef (IDLE, RAMP, KILLED)
  - DUTY_W default
  - DUTY_MAX default
  - sat_inc/sat_dec helper functions
- One sub-module, pwm_step_timer: period_end counter with terminal-count pulse output and synchronous clear, parameterised by STEP_DIV.

Test Plan:
1. Reset release, no inputs, 20 period_end pulses -> duty=5, target=5, busy=0 throughout. With SOFT_START_EN and STEP_DIV=4, duty steps 0→1 on the 4th period_end and reaches 5 on the 20th, with one at_target pulse.
2. Load 9 while duty=5, STEP_DIV=4 -> target=9 next cycle, busy=1. Duty changes only on period_end cycles: 6,7,8,9 at the 4th, 8th, 12th and 16th period_end. Then busy=0 and one at_target pulse.
3. 7 inc_pulses from target=5 -> target saturates at 10. Then 12 dec_pulses -> target saturates at 0. Same-cycle inc+dec -> target unchanged.
4. Load 15 -> target clamps to 10. load_valid held during kill -> load_ready=0 and no accept. Load with inc in the same cycle -> only the load applies.
5. Mid-ramp from 2→8 at duty=5, assert kill for 3 cycles without period_end -> duty=0 and target=0 one cycle later. After release: IDLE, busy=0, load_ready=1.
6. Retarget mid-ramp: duty=6 rising to 9, load 3 -> the next step event gives duty=5, then the ramp continues down to 3 with no jump. Async rst asserted mid-ramp -> outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types, default widths and saturating helpers for the
//                PWM duty sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int c_DUTY_W   = 4;
    localparam int c_DUTY_MAX = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_KILLED = 2'd2
    } state_e;

    function automatic int sat_inc(input int value, input int max_val);
        return (value >= max_val) ? max_val : value + 1;
    endfunction

    function automatic int sat_dec(input int value);
        return (value <= 0) ? 0 : value - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_step_timer
//  Description : Counts enabled period_end pulses; o_tick fires on the
//                enabled cycle that completes STEP_DIV periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                 c_cnt_w = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(STEP_DIV - 1);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    assign o_tick = i_en && (count_q == c_last);

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = o_tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_sequencer
//  Description : Owns the PWM duty register; ramps duty toward a target one
//                step per STEP_DIV periods, glitch-free at period boundaries.
//                Optional SOFT_START_EN: ramp up from 0 after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int DUTY_W    = c_DUTY_W,
    parameter int DUTY_MAX  = c_DUTY_MAX,
    parameter int DUTY_INIT = 5,
    parameter int STEP_DIV  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_end,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic              load_valid,
    input  logic [DUTY_W-1:0] load_duty,
    output logic              load_ready,
    input  logic              kill,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] target,
    output logic              busy,
    output logic              at_target
);

    localparam logic [DUTY_W-1:0] c_duty_max  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] c_duty_init = DUTY_W'(DUTY_INIT);
`ifdef SOFT_START_EN
    localparam logic [DUTY_W-1:0] c_rst_duty  = '0;
    localparam state_e            c_rst_state = ST_RAMP;
`else
    localparam logic [DUTY_W-1:0] c_rst_duty  = c_duty_init;
    localparam state_e            c_rst_state = ST_IDLE;
`endif
    localparam logic              c_rst_busy  = (c_rst_duty != c_duty_init);

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic              busy_q, busy_d;
    logic              at_target_q, at_target_d;

    logic              w_ready;
    logic              w_load_fire;
    logic              w_step_tick;

    // Ready drops combinationally with kill so a load can never race a kill.
    assign w_ready     = !rst && !kill && (state_q != ST_KILLED);
    assign w_load_fire = load_valid && w_ready;

    pwm_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (period_end && (state_q == ST_RAMP)),
        .i_clr  (kill || (state_q != ST_RAMP)),
        .o_tick (w_step_tick)
    );

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        target_d    = target_q;
        at_target_d = 1'b0;

        if (kill) begin
            state_d  = ST_KILLED;
            duty_d   = '0;
            target_d = '0;
        end else begin
            case (state_q)
                ST_KILLED: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    if (w_load_fire) begin
                        target_d = (load_duty > c_duty_max) ? c_duty_max : load_duty;
                    end else if (inc_pulse && !dec_pulse) begin
                        target_d = DUTY_W'(sat_inc(int'(target_q), DUTY_MAX));
                    end else if (dec_pulse && !inc_pulse) begin
                        target_d = DUTY_W'(sat_dec(int'(target_q)));
                    end

                    if (state_q == ST_IDLE) begin
                        if (target_q != duty_q) begin
                            state_d = ST_RAMP;
                        end
                    end else if (duty_q == target_q) begin
                        state_d     = ST_IDLE;
                        at_target_d = 1'b1;
                    end else if (w_step_tick) begin
                        duty_d = (duty_q < target_q) ? duty_q + 1'b1 : duty_q - 1'b1;
                    end
                end
            endcase
        end

        busy_d = (duty_d != target_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_rst_state;
            duty_q      <= c_rst_duty;
            target_q    <= c_duty_init;
            busy_q      <= c_rst_busy;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
        end
    end

    assign load_ready = w_ready;
    assign duty       = duty_q;
    assign target     = target_q;
    assign busy       = busy_q;
    assign at_target  = at_target_q;

endmodule
`default_nettype wire
